// File: rtl/range_tracker_pkg.sv
// Shared types and default widths for the range tracker and its bus interface.
package range_pkg;

  typedef enum logic {RT_IDLE, RT_ACTIVE} rt_state_t;

  localparam int RT_WIDTH_DEF  = 16;
  localparam int RT_SIGNED_DEF = 0;
  localparam int RT_CNT_W_DEF  = 8;

endpackage

// File: rtl/range_tracker_if.sv
// Sample stream in (data_in framed by go/finish) and sequence results out.
interface range_tracker_if
  import range_pkg::*;
#(
  parameter int WIDTH = RT_WIDTH_DEF,
  parameter int CNT_W = RT_CNT_W_DEF
);
  logic [WIDTH-1:0] data_in;
  logic             go;
  logic             finish;
  logic [WIDTH-1:0] range;
  logic [WIDTH-1:0] min_out;
  logic [WIDTH-1:0] max_out;
  logic [CNT_W-1:0] count;
  logic             done;
  logic             error;

  modport master (
    output data_in, go, finish,
    input  range, min_out, max_out, count, done, error
  );

  modport slave (
    input  data_in, go, finish,
    output range, min_out, max_out, count, done, error
  );
endinterface

// File: rtl/range_tracker_minmax.sv
// Folds one sample into a running min/max pair; SIGNED selects the compare flavour.
module minmax_unit #(
  parameter int WIDTH  = 16,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] cur_min,
  input  logic [WIDTH-1:0] cur_max,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] next_min,
  output logic [WIDTH-1:0] next_max
);
  logic signed [WIDTH-1:0] s_min, s_max, s_sample;
  logic                    lt_min, gt_max;

  assign s_min    = cur_min;
  assign s_max    = cur_max;
  assign s_sample = sample;

  always_comb begin
    if (SIGNED != 0) begin
      lt_min = s_sample < s_min;
      gt_max = s_sample > s_max;
    end else begin
      lt_min = sample < cur_min;
      gt_max = sample > cur_max;
    end
    next_min = lt_min ? sample : cur_min;
    next_max = gt_max ? sample : cur_max;
  end
endmodule

// File: rtl/range_tracker.sv
// Running min/max/count over a go..finish framed sample sequence, with a done
// pulse on completion and a sticky protocol-error flag.
module range_tracker
  import range_pkg::*;
#(
  parameter int WIDTH  = RT_WIDTH_DEF,
  parameter int SIGNED = RT_SIGNED_DEF,
  parameter int CNT_W  = RT_CNT_W_DEF
) (
  input  logic           clock,
  input  logic           reset,
  range_tracker_if.slave bus
);
  rt_state_t        state_q, state_d;
  logic [WIDTH-1:0] run_min_q, run_min_d, run_max_q, run_max_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [WIDTH-1:0] range_q, range_d, min_q, min_d, max_q, max_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d, error_q, error_d;
  logic [WIDTH-1:0] fold_min, fold_max;
  logic [CNT_W-1:0] fold_cnt;
  logic             violation;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  minmax_unit #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_minmax (
    .cur_min  (run_min_q),
    .cur_max  (run_max_q),
    .sample   (bus.data_in),
    .next_min (fold_min),
    .next_max (fold_max)
  );

  assign fold_cnt  = sat_inc(run_cnt_q);
  assign violation = (bus.go & bus.finish)
                   | (bus.go & (state_q == RT_ACTIVE))
                   | (bus.finish & (state_q == RT_IDLE));

  always_comb begin
    state_d   = state_q;
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    run_cnt_d = run_cnt_q;
    range_d   = range_q;
    min_d     = min_q;
    max_d     = max_q;
    count_d   = count_q;
    error_d   = error_q;
    done_d    = 1'b0;
    // A violation drops the open sequence; published results stay untouched.
    if (violation) begin
      state_d = RT_IDLE;
      error_d = 1'b1;
    end else if (state_q == RT_IDLE) begin
      if (bus.go) begin
        run_min_d = bus.data_in;
        run_max_d = bus.data_in;
        run_cnt_d = CNT_W'(1);
        state_d   = RT_ACTIVE;
        error_d   = 1'b0;
      end
    end else begin
      run_min_d = fold_min;
      run_max_d = fold_max;
      run_cnt_d = fold_cnt;
      if (bus.finish) begin
        min_d   = fold_min;
        max_d   = fold_max;
        range_d = fold_max - fold_min;
        count_d = fold_cnt;
        done_d  = 1'b1;
        state_d = RT_IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RT_IDLE;
      run_min_q <= '0;
      run_max_q <= '0;
      run_cnt_q <= '0;
      range_q   <= '0;
      min_q     <= '0;
      max_q     <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
      run_cnt_q <= run_cnt_d;
      range_q   <= range_d;
      min_q     <= min_d;
      max_q     <= max_d;
      count_q   <= count_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign bus.range   = range_q;
  assign bus.min_out = min_q;
  assign bus.max_out = max_q;
  assign bus.count   = count_q;
  assign bus.done    = done_q;
  assign bus.error   = error_q;
endmodule

// File: tb/tb_range_tracker.sv
// Bench for range_tracker: three configurations share one stimulus stream and
// a sequence-level reference model feeds a scoreboard of expected results.
module tb_range_tracker;
  typedef struct packed {
    logic [15:0] mn;
    logic [15:0] mx;
    logic [15:0] rg;
    logic [7:0]  cnt;
  } res_t;

  typedef struct packed {
    res_t u;   // SIGNED=0, CNT_W=8
    res_t s;   // SIGNED=1, CNT_W=8
    res_t c4;  // SIGNED=0, CNT_W=4
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = '0;
  logic        go_r = 1'b0;
  logic        fin_r = 1'b0;

  int          vecs = 0;
  int          miss = 0;
  exp_t        sb[$];
  logic [15:0] smp[$];
  bit          m_active = 0;
  res_t        last_u = '0;

  always #5 clk = ~clk;

  range_tracker_if #(.WIDTH(16), .CNT_W(8)) if0 ();
  range_tracker_if #(.WIDTH(16), .CNT_W(8)) if1 ();
  range_tracker_if #(.WIDTH(16), .CNT_W(4)) if2 ();

  assign if0.data_in = din;
  assign if0.go      = go_r;
  assign if0.finish  = fin_r;
  assign if1.data_in = din;
  assign if1.go      = go_r;
  assign if1.finish  = fin_r;
  assign if2.data_in = din;
  assign if2.go      = go_r;
  assign if2.finish  = fin_r;

  range_tracker #(.WIDTH(16), .SIGNED(0), .CNT_W(8)) dut0 (.clock(clk), .reset(rst), .bus(if0));
  range_tracker #(.WIDTH(16), .SIGNED(1), .CNT_W(8)) dut1 (.clock(clk), .reset(rst), .bus(if1));
  range_tracker #(.WIDTH(16), .SIGNED(0), .CNT_W(4)) dut2 (.clock(clk), .reset(rst), .bus(if2));

  function automatic res_t calc(input bit sgn, input int cw);
    res_t        r;
    logic [15:0] mn, mx;
    int          cap;
    mn = smp[0];
    mx = smp[0];
    foreach (smp[i]) begin
      if (sgn ? ($signed(smp[i]) < $signed(mn)) : (smp[i] < mn)) mn = smp[i];
      if (sgn ? ($signed(smp[i]) > $signed(mx)) : (smp[i] > mx)) mx = smp[i];
    end
    cap   = (1 << cw) - 1;
    r.mn  = mn;
    r.mx  = mx;
    r.rg  = mx - mn;
    r.cnt = 8'((smp.size() > cap) ? cap : smp.size());
    return r;
  endfunction

  // Drive one cycle, advance the reference model, then settle past the edge.
  task automatic cyc(input logic [15:0] d, input logic g, input logic f, input logic r);
    exp_t e;
    din = d; go_r = g; fin_r = f; rst = r;
    if (r) begin
      m_active = 0; smp.delete(); last_u = '0;
    end else if ((g && f) || (g && m_active) || (f && !m_active)) begin
      m_active = 0; smp.delete();
    end else if (g) begin
      m_active = 1; smp.delete(); smp.push_back(d);
    end else if (m_active) begin
      smp.push_back(d);
      if (f) begin
        e.u = calc(0, 8); e.s = calc(1, 8); e.c4 = calc(0, 4);
        sb.push_back(e);
        m_active = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(16'h0, 0, 0, 1);
    cyc(16'h0, 0, 0, 1);
    vecs++; if (if0.range !== 16'h0)   begin miss++; $display("FAIL reset_range: got %h want 0000", if0.range); end
    vecs++; if (if0.min_out !== 16'h0) begin miss++; $display("FAIL reset_min: got %h want 0000", if0.min_out); end
    vecs++; if (if0.max_out !== 16'h0) begin miss++; $display("FAIL reset_max: got %h want 0000", if0.max_out); end
    vecs++; if (if0.count !== 8'h0)    begin miss++; $display("FAIL reset_count: got %h want 00", if0.count); end
    vecs++; if (if0.done !== 1'b0)     begin miss++; $display("FAIL reset_done: got %b want 0", if0.done); end
    vecs++; if (if0.error !== 1'b0)    begin miss++; $display("FAIL reset_error: got %b want 0", if0.error); end
    cyc(16'h0, 0, 0, 0);
  endtask

  task automatic test_signed();
    exp_t e;
    cyc(16'hFFF0, 1, 0, 0);
    cyc(16'h0010, 0, 1, 0);
    e = sb.pop_front(); last_u = e.u;
    vecs++; if (if1.done !== 1'b1)    begin miss++; $display("FAIL signed_done: got %b want 1", if1.done); end
    vecs++; if (if1.min_out !== e.s.mn) begin miss++; $display("FAIL signed_min: got %h want %h", if1.min_out, e.s.mn); end
    vecs++; if (if1.max_out !== e.s.mx) begin miss++; $display("FAIL signed_max: got %h want %h", if1.max_out, e.s.mx); end
    vecs++; if (if1.range !== 16'h0020) begin miss++; $display("FAIL signed_range: got %h want 0020", if1.range); end
    vecs++; if (if1.count !== e.s.cnt)  begin miss++; $display("FAIL signed_count: got %h want %h", if1.count, e.s.cnt); end
    vecs++; if (if0.range !== 16'hFFE0) begin miss++; $display("FAIL unsigned_range: got %h want ffe0", if0.range); end
    vecs++; if (if0.min_out !== e.u.mn) begin miss++; $display("FAIL unsigned_min: got %h want %h", if0.min_out, e.u.mn); end
    cyc(16'h0, 0, 0, 0);
    vecs++; if (if1.done !== 1'b0)    begin miss++; $display("FAIL signed_done_pulse: got %b want 0", if1.done); end
  endtask

  task automatic test_basic();
    exp_t e;
    cyc(16'h0010, 1, 0, 0);
    cyc(16'h0005, 0, 0, 0);
    vecs++; if (if0.done !== 1'b0) begin miss++; $display("FAIL basic_early_done: got %b want 0", if0.done); end
    cyc(16'h0030, 0, 0, 0);
    cyc(16'h0020, 0, 1, 0);
    e = sb.pop_front(); last_u = e.u;
    vecs++; if (if0.done !== 1'b1)      begin miss++; $display("FAIL basic_done: got %b want 1", if0.done); end
    vecs++; if (if0.min_out !== e.u.mn) begin miss++; $display("FAIL basic_min: got %h want %h", if0.min_out, e.u.mn); end
    vecs++; if (if0.max_out !== e.u.mx) begin miss++; $display("FAIL basic_max: got %h want %h", if0.max_out, e.u.mx); end
    vecs++; if (if0.range !== 16'h002B) begin miss++; $display("FAIL basic_range: got %h want 002b", if0.range); end
    vecs++; if (if0.count !== 8'd4)     begin miss++; $display("FAIL basic_count: got %0d want 4", if0.count); end
    vecs++; if (if0.error !== 1'b0)     begin miss++; $display("FAIL basic_error: got %b want 0", if0.error); end
    cyc(16'h0, 0, 0, 0);
    vecs++; if (if0.done !== 1'b0)      begin miss++; $display("FAIL basic_done_pulse: got %b want 0", if0.done); end
    vecs++; if (if0.range !== e.u.rg)   begin miss++; $display("FAIL basic_hold: got %h want %h", if0.range, e.u.rg); end
  endtask

  task automatic test_go_finish();
    exp_t e;
    cyc(16'h1234, 1, 1, 0);
    vecs++; if (if0.error !== 1'b1)     begin miss++; $display("FAIL gofin_error: got %b want 1", if0.error); end
    vecs++; if (if0.done !== 1'b0)      begin miss++; $display("FAIL gofin_done: got %b want 0", if0.done); end
    vecs++; if (if0.range !== 16'h002B) begin miss++; $display("FAIL gofin_range: got %h want 002b", if0.range); end
    cyc(16'h0, 0, 0, 0);
    vecs++; if (if0.done !== 1'b0)      begin miss++; $display("FAIL gofin_done2: got %b want 0", if0.done); end
    cyc(16'h0007, 1, 0, 0);
    vecs++; if (if0.error !== 1'b0)     begin miss++; $display("FAIL gofin_clear: got %b want 0", if0.error); end
    cyc(16'h0009, 0, 1, 0);
    e = sb.pop_front(); last_u = e.u;
    vecs++; if (if0.done !== 1'b1)      begin miss++; $display("FAIL gofin_redone: got %b want 1", if0.done); end
    vecs++; if (if0.max_out !== e.u.mx) begin miss++; $display("FAIL gofin_max: got %h want %h", if0.max_out, e.u.mx); end
  endtask

  task automatic test_go_active();
    exp_t e;
    cyc(16'h0100, 1, 0, 0);
    cyc(16'h0200, 0, 0, 0);
    cyc(16'h0300, 1, 0, 0);
    vecs++; if (if0.error !== 1'b1)       begin miss++; $display("FAIL goact_error: got %b want 1", if0.error); end
    vecs++; if (if0.done !== 1'b0)        begin miss++; $display("FAIL goact_done: got %b want 0", if0.done); end
    vecs++; if (if0.range !== last_u.rg)  begin miss++; $display("FAIL goact_hold: got %h want %h", if0.range, last_u.rg); end
    // A clean go must now be accepted, which only happens from IDLE.
    cyc(16'h0050, 1, 0, 0);
    vecs++; if (if0.error !== 1'b0)       begin miss++; $display("FAIL goact_clear: got %b want 0", if0.error); end
    cyc(16'h0060, 0, 1, 0);
    e = sb.pop_front(); last_u = e.u;
    vecs++; if (if0.done !== 1'b1)        begin miss++; $display("FAIL goact_done2: got %b want 1", if0.done); end
    vecs++; if (if0.count !== e.u.cnt)    begin miss++; $display("FAIL goact_count: got %0d want %0d", if0.count, e.u.cnt); end
    cyc(16'h0, 0, 1, 0);
    vecs++; if (if0.error !== 1'b1)       begin miss++; $display("FAIL finidle_error: got %b want 1", if0.error); end
    for (int i = 0; i < 5; i++) begin
      cyc(16'(i), 0, 0, 0);
      vecs++; if (if0.error !== 1'b1)     begin miss++; $display("FAIL sticky_error%0d: got %b want 1", i, if0.error); end
      vecs++; if (if0.done !== 1'b0)      begin miss++; $display("FAIL sticky_done%0d: got %b want 0", i, if0.done); end
    end
    cyc(16'h0070, 1, 0, 0);
    vecs++; if (if0.error !== 1'b0)       begin miss++; $display("FAIL sticky_clear: got %b want 0", if0.error); end
    cyc(16'h0001, 0, 1, 0);
    e = sb.pop_front(); last_u = e.u;
    vecs++; if (if0.min_out !== e.u.mn)   begin miss++; $display("FAIL sticky_min: got %h want %h", if0.min_out, e.u.mn); end
  endtask

  task automatic test_reset_mid();
    cyc(16'hAAAA, 1, 0, 0);
    cyc(16'h5555, 0, 0, 0);
    cyc(16'h1111, 0, 1, 1);
    vecs++; if (if0.done !== 1'b0)     begin miss++; $display("FAIL rstmid_done: got %b want 0", if0.done); end
    vecs++; if (if0.range !== 16'h0)   begin miss++; $display("FAIL rstmid_range: got %h want 0000", if0.range); end
    vecs++; if (if0.min_out !== 16'h0) begin miss++; $display("FAIL rstmid_min: got %h want 0000", if0.min_out); end
    vecs++; if (if0.count !== 8'h0)    begin miss++; $display("FAIL rstmid_count: got %h want 00", if0.count); end
    cyc(16'h2222, 0, 1, 0);
    vecs++; if (if0.done !== 1'b0)     begin miss++; $display("FAIL rstmid_done2: got %b want 0", if0.done); end
    vecs++; if (if0.error !== 1'b1)    begin miss++; $display("FAIL rstmid_idle_fin: got %b want 1", if0.error); end
  endtask

  task automatic test_saturation();
    exp_t e;
    cyc(16'($urandom_range(0, 65535)), 1, 0, 0);
    for (int i = 0; i < 18; i++) cyc(16'($urandom_range(0, 65535)), 0, 0, 0);
    cyc(16'($urandom_range(0, 65535)), 0, 1, 0);
    e = sb.pop_front(); last_u = e.u;
    vecs++; if (if2.count !== 4'hF)     begin miss++; $display("FAIL sat_count4: got %h want f", if2.count); end
    vecs++; if (if2.done !== 1'b1)      begin miss++; $display("FAIL sat_done: got %b want 1", if2.done); end
    vecs++; if (if0.count !== 8'd20)    begin miss++; $display("FAIL sat_count8: got %0d want 20", if0.count); end
    vecs++; if (if0.range !== e.u.rg)   begin miss++; $display("FAIL sat_range: got %h want %h", if0.range, e.u.rg); end
    vecs++; if (if1.min_out !== e.s.mn) begin miss++; $display("FAIL sat_smin: got %h want %h", if1.min_out, e.s.mn); end
    vecs++; if (if1.max_out !== e.s.mx) begin miss++; $display("FAIL sat_smax: got %h want %h", if1.max_out, e.s.mx); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      cyc(16'($urandom_range(0, 65535)), 1, 0, 0);
      if (i > 0) begin
        vecs++; if (if0.done !== 1'b0) begin miss++; $display("FAIL b2b_go_done%0d: got %b want 0", i, if0.done); end
      end
      cyc(16'($urandom_range(0, 65535)), 0, 1, 0);
      e = sb.pop_front(); last_u = e.u;
      vecs++; if (if0.done !== 1'b1)      begin miss++; $display("FAIL b2b_done%0d: got %b want 1", i, if0.done); end
      vecs++; if (if0.range !== e.u.rg)   begin miss++; $display("FAIL b2b_range%0d: got %h want %h", i, if0.range, e.u.rg); end
      vecs++; if (if1.range !== e.s.rg)   begin miss++; $display("FAIL b2b_srange%0d: got %h want %h", i, if1.range, e.s.rg); end
      vecs++; if (if0.count !== 8'd2)     begin miss++; $display("FAIL b2b_count%0d: got %0d want 2", i, if0.count); end
    end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_basic();
    test_go_finish();
    test_go_active();
    test_reset_mid();
    test_saturation();
    test_back_to_back();
    vecs++; if (sb.size() != 0) begin miss++; $display("FAIL scoreboard_left: got %0d want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
